// File: rtl/tlul_rsp_intg_gen_reg.sv
// TL-UL D-channel response slice with integrity generation and checking.
// A two-entry valid/ready register slice (output register plus skid entry)
// carries each response beat. Response and per-lane data integrity are
// computed from the incoming fields at accept time and stored with the beat.
// The incoming integrity can optionally be checked, with sticky status and a
// saturating mismatch counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_EMPTY | no beat held; d_valid_o=0, d_ready_o=1
// S_ONE   | output register holds a beat; skid entry empty, d_ready_o=1
// S_FULL  | output and skid registers both hold beats; d_ready_o=0

module tlul_rsp_intg_gen_reg #(
  parameter int DataWidth         = 32,
  parameter int SzW               = 2,
  parameter int MiscWidth         = 17,
  parameter int EnableRspIntgGen  = 1,
  parameter int EnableDataIntgGen = 1,
  parameter int CheckInIntg       = 0,
  parameter int ErrCntWidth       = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          d_valid_i,
  output logic                          d_ready_o,
  input  logic [2:0]                    d_opcode_i,
  input  logic [SzW-1:0]                d_size_i,
  input  logic                          d_error_i,
  input  logic [MiscWidth-1:0]          d_misc_i,
  input  logic [DataWidth-1:0]          d_data_i,
  input  logic [6:0]                    d_rsp_intg_i,
  input  logic [7*(DataWidth/32)-1:0]   d_data_intg_i,
  output logic                          d_valid_o,
  input  logic                          d_ready_i,
  output logic [2:0]                    d_opcode_o,
  output logic [SzW-1:0]                d_size_o,
  output logic                          d_error_o,
  output logic [MiscWidth-1:0]          d_misc_o,
  output logic [DataWidth-1:0]          d_data_o,
  output logic [6:0]                    d_rsp_intg_o,
  output logic [7*(DataWidth/32)-1:0]   d_data_intg_o,
  input  logic                          err_clr_i,
  output logic                          intg_err_o,
  output logic                          intg_err_sticky_o,
  output logic [ErrCntWidth-1:0]        err_cnt_o
);

  localparam int NumLanes = DataWidth / 32;
  localparam int DiW      = 7 * NumLanes;
  localparam int BeatW    = 3 + SzW + 1 + MiscWidth + DataWidth + 7 + DiW;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } slice_state_e;

  // Inverted SECDED (64,57) encoder, check bits only.
  function automatic logic [6:0] f_rsp_intg(input logic [56:0] d);
    logic [63:0] w;
    logic [6:0]  c;
    w    = {7'b0, d};
    c[0] = ^(w & 64'h0103FFF800007FFF);
    c[1] = ^(w & 64'h017C1FF801FF801F);
    c[2] = ^(w & 64'h01BDE1F87E0781E1);
    c[3] = ^(w & 64'h01DEEE3B8E388E22);
    c[4] = ^(w & 64'h01EF76CDB2C93244);
    c[5] = ^(w & 64'h01F7BB56D5525488);
    c[6] = ^(w & 64'h01FBDDA769A46910);
    return c ^ 7'h2A;
  endfunction

  // Inverted SECDED (39,32) encoder, check bits only.
  function automatic logic [6:0] f_data_intg(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c ^ 7'h2A;
  endfunction

  slice_state_e r_state;
  slice_state_e w_state_nxt;
  logic         r_valid;
  logic         r_ready;

  logic [BeatW-1:0]       r_out;
  logic [BeatW-1:0]       r_skid;
  logic [BeatW-1:0]       w_beat_in;

  logic                   w_acc;
  logic                   w_emit;
  logic                   w_load_out_in;
  logic                   w_load_out_skid;
  logic                   w_load_skid;

  logic [56:0]            w_rsp_payload;
  logic [6:0]             w_rsp_intg_calc;
  logic [DiW-1:0]         w_data_intg_calc;
  logic [6:0]             w_rsp_intg_sel;
  logic [DiW-1:0]         w_data_intg_sel;
  logic                   w_mismatch;

  logic                   r_intg_err;
  logic                   r_sticky;
  logic [ErrCntWidth-1:0] r_err_cnt;

  assign w_acc  = d_valid_i & r_ready;
  assign w_emit = r_valid & d_ready_i;

  // Integrity is always recomputed so the checker can use it even when
  // the generator is disabled and the input value is passed through.
  assign w_rsp_payload   = 57'({d_opcode_i, d_size_i, d_error_i});
  assign w_rsp_intg_calc = f_rsp_intg(w_rsp_payload);

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    assign w_data_intg_calc[7*k +: 7] = f_data_intg(d_data_i[32*k +: 32]);
  end

  assign w_rsp_intg_sel  = (EnableRspIntgGen != 0)  ? w_rsp_intg_calc  : d_rsp_intg_i;
  assign w_data_intg_sel = (EnableDataIntgGen != 0) ? w_data_intg_calc : d_data_intg_i;

  assign w_beat_in = {d_opcode_i, d_size_i, d_error_i, d_misc_i, d_data_i,
                      w_rsp_intg_sel, w_data_intg_sel};

  assign w_mismatch = (CheckInIntg != 0) && w_acc &&
                      ((d_rsp_intg_i != w_rsp_intg_calc) ||
                       (d_data_intg_i != w_data_intg_calc));

  // Slice state plus flopped valid/ready decoded from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != S_EMPTY);
      r_ready <= (w_state_nxt != S_FULL);
    end
  end

  // Next-state selection from accept/emit handshakes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_acc && !w_emit)      w_state_nxt = S_FULL;
        else if (!w_acc && w_emit) w_state_nxt = S_EMPTY;
      end
      S_FULL:  if (w_emit) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Register load enables for the output and skid entries.
  always_comb begin
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: w_load_out_in = w_acc;
      S_ONE: begin
        w_load_out_in = w_acc & w_emit;
        w_load_skid   = w_acc & ~w_emit;
      end
      S_FULL:  w_load_out_skid = w_emit;
      default: ;
    endcase
  end

  // Beat storage; the skid entry only ever feeds the output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out_in)        r_out <= w_beat_in;
      else if (w_load_out_skid) r_out <= r_skid;
      if (w_load_skid)          r_skid <= w_beat_in;
    end
  end

  // Mismatch pulse, sticky flag and saturating counter; clear takes
  // priority but a simultaneous mismatch still registers once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_intg_err <= 1'b0;
      r_sticky   <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_intg_err <= w_mismatch;
      if (err_clr_i) begin
        r_sticky  <= w_mismatch;
        r_err_cnt <= w_mismatch ? ErrCntWidth'(1) : '0;
      end else if (w_mismatch) begin
        r_sticky <= 1'b1;
        if (r_err_cnt != {ErrCntWidth{1'b1}}) r_err_cnt <= r_err_cnt + ErrCntWidth'(1);
      end
    end
  end

  assign d_valid_o = r_valid;
  assign d_ready_o = r_ready;
  assign {d_opcode_o, d_size_o, d_error_o, d_misc_o, d_data_o,
          d_rsp_intg_o, d_data_intg_o} = r_out;

  assign intg_err_o        = r_intg_err;
  assign intg_err_sticky_o = r_sticky;
  assign err_cnt_o         = r_err_cnt;

endmodule

// File: tb/tb_tlul_rsp_intg_gen_reg.sv
// Directed bench for tlul_rsp_intg_gen_reg. Three instances share stimulus:
// a = 64-bit checker, b = 2-bit saturating counter, c = data-intg passthrough.
module tb_tlul_rsp_intg_gen_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        d_valid_i, d_ready_i, err_clr_i;
  logic [2:0]  d_opcode_i;
  logic [1:0]  d_size_i;
  logic        d_error_i;
  logic [16:0] d_misc_i;
  logic [63:0] d_data_i;
  logic [6:0]  d_rsp_intg_i;
  logic [13:0] d_data_intg_i;

  logic a_valid, a_ready, a_error, a_ierr, a_sticky;
  logic [2:0] a_op; logic [1:0] a_sz; logic [16:0] a_misc; logic [63:0] a_data;
  logic [6:0] a_rsp; logic [13:0] a_di; logic [7:0] a_cnt;
  logic b_valid, b_ready, b_error, b_ierr, b_sticky;
  logic [2:0] b_op; logic [1:0] b_sz; logic [16:0] b_misc; logic [63:0] b_data;
  logic [6:0] b_rsp; logic [13:0] b_di; logic [1:0] b_cnt;
  logic c_valid, c_ready, c_error, c_ierr, c_sticky;
  logic [2:0] c_op; logic [1:0] c_sz; logic [16:0] c_misc; logic [63:0] c_data;
  logic [6:0] c_rsp; logic [13:0] c_di; logic [7:0] c_cnt;

  int n_checks = 0;
  int n_errors = 0;

  tlul_rsp_intg_gen_reg #(.DataWidth(64), .CheckInIntg(1), .ErrCntWidth(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .d_valid_i(d_valid_i), .d_ready_o(a_ready),
    .d_opcode_i(d_opcode_i), .d_size_i(d_size_i), .d_error_i(d_error_i), .d_misc_i(d_misc_i),
    .d_data_i(d_data_i), .d_rsp_intg_i(d_rsp_intg_i), .d_data_intg_i(d_data_intg_i),
    .d_valid_o(a_valid), .d_ready_i(d_ready_i), .d_opcode_o(a_op), .d_size_o(a_sz),
    .d_error_o(a_error), .d_misc_o(a_misc), .d_data_o(a_data), .d_rsp_intg_o(a_rsp),
    .d_data_intg_o(a_di), .err_clr_i(err_clr_i), .intg_err_o(a_ierr),
    .intg_err_sticky_o(a_sticky), .err_cnt_o(a_cnt));

  tlul_rsp_intg_gen_reg #(.DataWidth(64), .CheckInIntg(1), .ErrCntWidth(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .d_valid_i(d_valid_i), .d_ready_o(b_ready),
    .d_opcode_i(d_opcode_i), .d_size_i(d_size_i), .d_error_i(d_error_i), .d_misc_i(d_misc_i),
    .d_data_i(d_data_i), .d_rsp_intg_i(d_rsp_intg_i), .d_data_intg_i(d_data_intg_i),
    .d_valid_o(b_valid), .d_ready_i(d_ready_i), .d_opcode_o(b_op), .d_size_o(b_sz),
    .d_error_o(b_error), .d_misc_o(b_misc), .d_data_o(b_data), .d_rsp_intg_o(b_rsp),
    .d_data_intg_o(b_di), .err_clr_i(err_clr_i), .intg_err_o(b_ierr),
    .intg_err_sticky_o(b_sticky), .err_cnt_o(b_cnt));

  tlul_rsp_intg_gen_reg #(.DataWidth(64), .EnableDataIntgGen(0), .CheckInIntg(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .d_valid_i(d_valid_i), .d_ready_o(c_ready),
    .d_opcode_i(d_opcode_i), .d_size_i(d_size_i), .d_error_i(d_error_i), .d_misc_i(d_misc_i),
    .d_data_i(d_data_i), .d_rsp_intg_i(d_rsp_intg_i), .d_data_intg_i(d_data_intg_i),
    .d_valid_o(c_valid), .d_ready_i(d_ready_i), .d_opcode_o(c_op), .d_size_o(c_sz),
    .d_error_o(c_error), .d_misc_o(c_misc), .d_data_o(c_data), .d_rsp_intg_o(c_rsp),
    .d_data_intg_o(c_di), .err_clr_i(err_clr_i), .intg_err_o(c_ierr),
    .intg_err_sticky_o(c_sticky), .err_cnt_o(c_cnt));

  // Reference encoders, written as a bit-by-bit parity walk over the H matrix rows.
  function automatic logic [6:0] m_lane(input logic [31:0] d);
    logic [6:0][31:0] mk;
    logic [6:0] c;
    mk = {32'h98505586, 32'h2DCC624C, 32'hC2C1323B, 32'h31234ED1,
          32'h413D89AA, 32'hDEBA8050, 32'h2606BD25};
    c = 7'h2A;
    for (int j = 0; j < 7; j++)
      for (int i = 0; i < 32; i++)
        if (d[i] && mk[j][i]) c[j] = ~c[j];
    return c;
  endfunction

  function automatic logic [6:0] m_rsp(input logic [5:0] p);
    logic [6:0][63:0] mk;
    logic [6:0] c;
    mk = {64'h01FBDDA769A46910, 64'h01F7BB56D5525488, 64'h01EF76CDB2C93244,
          64'h01DEEE3B8E388E22, 64'h01BDE1F87E0781E1, 64'h017C1FF801FF801F,
          64'h0103FFF800007FFF};
    c = 7'h2A;
    for (int j = 0; j < 7; j++)
      for (int i = 0; i < 6; i++)
        if (p[i] && mk[j][i]) c[j] = ~c[j];
    return c;
  endfunction

  task automatic drive_beat(input logic [2:0] op, input logic [1:0] sz, input logic er,
                            input logic [16:0] misc, input logic [63:0] data, input logic corrupt);
    d_opcode_i    = op;
    d_size_i      = sz;
    d_error_i     = er;
    d_misc_i      = misc;
    d_data_i      = data;
    d_rsp_intg_i  = m_rsp({op, sz, er});
    d_data_intg_i = {m_lane(data[63:32]), m_lane(data[31:0])};
    if (corrupt) d_data_intg_i[9] = ~d_data_intg_i[9];
    d_valid_i     = 1'b1;
  endtask

  task automatic drive_idle();
    d_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    err_clr_i = 1'b0;
    d_ready_i = 1'b1;
    drive_beat(3'd0, 2'd0, 1'b1, 17'h0, 64'h0000_0001_0000_0001, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b want 0", a_valid); end
    n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b want 1", a_ready); end
    n_checks++; if (a_cnt !== 8'd0 || a_sticky !== 1'b0 || a_ierr !== 1'b0) begin
      n_errors++; $display("FAIL reset_err: cnt %0d sticky %0b pulse %0b want 0", a_cnt, a_sticky, a_ierr); end
    n_checks++; if (a_data !== 64'h0 || a_rsp !== 7'h0 || a_di !== 14'h0) begin
      n_errors++; $display("FAIL reset_data: data %h rsp %h di %h want 0", a_data, a_rsp, a_di); end
    rst = 1'b0;
    @(negedge clk);
    drive_idle();
    n_checks++; if (a_valid !== 1'b1) begin n_errors++; $display("FAIL first_valid: got %0b want 1", a_valid); end
    n_checks++; if (a_data !== 64'h0000_0001_0000_0001 || a_error !== 1'b1) begin
      n_errors++; $display("FAIL first_data: got %h err %0b", a_data, a_error); end
    n_checks++; if (a_rsp !== 7'h2D) begin n_errors++; $display("FAIL first_rsp_intg: got %h want 2d", a_rsp); end
    n_checks++; if (a_di !== 14'h19B3) begin n_errors++; $display("FAIL first_data_intg: got %h want 19b3", a_di); end
    @(negedge clk);
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL first_drain: got %0b want 0", a_valid); end
  endtask

  task automatic test_encode();
    logic [63:0] dat;
    logic [2:0]  op;
    logic [1:0]  sz;
    logic        er;
    @(negedge clk);
    drive_beat(3'd0, 2'd0, 1'b0, 17'h0, 64'h0, 1'b0);
    @(negedge clk);
    drive_idle();
    n_checks++; if (a_rsp !== 7'h2A) begin n_errors++; $display("FAIL zero_rsp_intg: got %h want 2a", a_rsp); end
    n_checks++; if (a_di !== 14'h152A) begin n_errors++; $display("FAIL zero_data_intg: got %h want 152a", a_di); end
    for (int i = 0; i < 6; i++) begin
      dat = {$urandom, $urandom};
      op  = 3'($urandom_range(0, 7));
      sz  = 2'($urandom_range(0, 3));
      er  = 1'($urandom_range(0, 1));
      @(negedge clk);
      drive_beat(op, sz, er, 17'($urandom), dat, 1'b0);
      @(negedge clk);
      drive_idle();
      n_checks++; if (a_data !== dat || a_op !== op) begin
        n_errors++; $display("FAIL rand_fields[%0d]: got %h/%0d want %h/%0d", i, a_data, a_op, dat, op); end
      n_checks++; if (a_di !== {m_lane(dat[63:32]), m_lane(dat[31:0])}) begin
        n_errors++; $display("FAIL rand_data_intg[%0d]: got %h want %h", i, a_di, {m_lane(dat[63:32]), m_lane(dat[31:0])}); end
      n_checks++; if (a_rsp !== m_rsp({op, sz, er})) begin
        n_errors++; $display("FAIL rand_rsp_intg[%0d]: got %h want %h", i, a_rsp, m_rsp({op, sz, er})); end
      n_checks++; if (a_ierr !== 1'b0) begin n_errors++; $display("FAIL rand_clean_pulse[%0d]: got 1 want 0", i); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_data [10];
    logic [2:0]  exp_op [10];
    int tx, rx, cyc, occ;
    logic rdy, saw_full;
    for (int i = 0; i < 10; i++) begin
      exp_data[i] = {32'hA5A5_0000 + 32'(i), 32'h0000_5A00 + 32'(i * 7)};
      exp_op[i]   = 3'(i);
    end
    tx = 0; rx = 0; cyc = 0; saw_full = 1'b0;
    while (rx < 10 && cyc < 60) begin
      @(negedge clk);
      occ = tx - rx;
      n_checks++; if (a_valid !== (occ > 0)) begin
        n_errors++; $display("FAIL stream_valid cyc %0d: got %0b occupancy %0d", cyc, a_valid, occ); end
      if (a_ready === 1'b0) begin
        saw_full = 1'b1;
        n_checks++; if (occ != 2) begin n_errors++; $display("FAIL stream_full_occ: got %0d want 2", occ); end
      end
      rdy = !(cyc >= 3 && cyc <= 5);
      d_ready_i = rdy;
      if (tx < 10) drive_beat(exp_op[tx], 2'd2, 1'b0, 17'(tx), exp_data[tx], 1'b0);
      else drive_idle();
      if (a_valid && rdy) begin
        n_checks++; if (a_data !== exp_data[rx] || a_op !== exp_op[rx]) begin
          n_errors++; $display("FAIL stream_beat[%0d]: got %h/%0d want %h/%0d", rx, a_data, a_op, exp_data[rx], exp_op[rx]); end
        rx++;
      end
      if (d_valid_i && a_ready) tx++;
      cyc++;
    end
    @(negedge clk);
    drive_idle();
    d_ready_i = 1'b1;
    n_checks++; if (rx != 10) begin n_errors++; $display("FAIL stream_count: got %0d beats want 10 (cycle budget)", rx); end
    n_checks++; if (saw_full !== 1'b1) begin n_errors++; $display("FAIL stream_backpressure: ready never dropped"); end
    n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL stream_drain: got valid %0b want 0", a_valid); end
  endtask

  task automatic test_check();
    logic [4:0] pat;
    logic [63:0] dat;
    pat = 5'b10101;
    @(negedge clk); err_clr_i = 1'b1;
    @(negedge clk); err_clr_i = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        n_checks++; if (a_ierr !== pat[cyc-1]) begin
          n_errors++; $display("FAIL check_pulse[%0d]: got %0b want %0b", cyc - 1, a_ierr, pat[cyc-1]); end
        n_checks++; if (c_ierr !== 1'b0) begin n_errors++; $display("FAIL nocheck_pulse[%0d]: got 1 want 0", cyc - 1); end
      end
      if (cyc == 1) begin
        n_checks++; if (a_di !== {m_lane(32'h1234_0000), m_lane(32'h0000_FFFF)}) begin
          n_errors++; $display("FAIL check_regen: got %h want %h", a_di, {m_lane(32'h1234_0000), m_lane(32'h0000_FFFF)}); end
      end
      if (cyc < 5) begin
        dat = {32'h1234_0000 + 32'(cyc), 32'h0000_FFFF - 32'(cyc)};
        drive_beat(3'd1, 2'd2, 1'b0, 17'h1_0000, dat, pat[cyc]);
      end else drive_idle();
    end
    @(negedge clk);
    n_checks++; if (a_sticky !== 1'b1) begin n_errors++; $display("FAIL check_sticky: got %0b want 1", a_sticky); end
    n_checks++; if (a_cnt !== 8'd3) begin n_errors++; $display("FAIL check_cnt: got %0d want 3", a_cnt); end
    n_checks++; if (c_sticky !== 1'b0 || c_cnt !== 8'd0) begin
      n_errors++; $display("FAIL nocheck_status: sticky %0b cnt %0d want 0", c_sticky, c_cnt); end
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    n_checks++; if (a_sticky !== 1'b0 || a_cnt !== 8'd0) begin
      n_errors++; $display("FAIL check_clear: sticky %0b cnt %0d want 0", a_sticky, a_cnt); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_beat(3'd4, 2'd1, 1'b1, 17'(i), {32'(i), 32'hCAFE_0000}, 1'b1);
    end
    @(negedge clk);
    drive_idle();
    n_checks++; if (b_cnt !== 2'd3) begin n_errors++; $display("FAIL sat_cnt: got %0d want 3", b_cnt); end
    n_checks++; if (a_cnt !== 8'd5) begin n_errors++; $display("FAIL wide_cnt: got %0d want 5", a_cnt); end
    @(negedge clk);
    drive_beat(3'd4, 2'd1, 1'b0, 17'h5, 64'h1, 1'b1);
    err_clr_i = 1'b1;
    @(negedge clk);
    drive_idle();
    err_clr_i = 1'b0;
    n_checks++; if (b_cnt !== 2'd1 || b_sticky !== 1'b1) begin
      n_errors++; $display("FAIL clr_and_err: cnt %0d sticky %0b want 1/1", b_cnt, b_sticky); end
    n_checks++; if (a_cnt !== 8'd1) begin n_errors++; $display("FAIL clr_and_err_wide: got %0d want 1", a_cnt); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    drive_beat(3'd0, 2'd0, 1'b1, 17'h0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    d_data_intg_i = 14'h2AD5;
    d_rsp_intg_i  = 7'h00;
    @(negedge clk);
    drive_idle();
    n_checks++; if (c_di !== 14'h2AD5) begin n_errors++; $display("FAIL pass_data_intg: got %h want 2ad5", c_di); end
    n_checks++; if (c_rsp !== 7'h2D) begin n_errors++; $display("FAIL pass_rsp_regen: got %h want 2d", c_rsp); end
    n_checks++; if (a_di !== {m_lane(32'hDEAD_BEEF), m_lane(32'h0123_4567)}) begin
      n_errors++; $display("FAIL gen_data_intg: got %h", a_di); end
    n_checks++; if (a_ierr !== 1'b1 || c_ierr !== 1'b0) begin
      n_errors++; $display("FAIL pass_pulses: a %0b c %0b want 1/0", a_ierr, c_ierr); end
  endtask

  task automatic test_reset_mid();
    d_ready_i = 1'b0;
    @(negedge clk); drive_beat(3'd1, 2'd0, 1'b0, 17'h1, 64'h11, 1'b0);
    @(negedge clk); drive_beat(3'd2, 2'd0, 1'b0, 17'h2, 64'h22, 1'b0);
    @(negedge clk); drive_idle();
    n_checks++; if (a_ready !== 1'b0 || a_valid !== 1'b1) begin
      n_errors++; $display("FAIL mid_full: ready %0b valid %0b want 0/1", a_ready, a_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_data !== 64'h0) begin
      n_errors++; $display("FAIL mid_reset: valid %0b ready %0b data %h", a_valid, a_ready, a_data); end
    @(negedge clk);
    rst = 1'b0;
    d_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (a_valid !== 1'b0) begin n_errors++; $display("FAIL mid_no_output[%0d]: got 1 want 0", i); end
    end
  endtask

  initial begin
    rst = 1'b1;
    d_valid_i = 1'b0; d_ready_i = 1'b1; err_clr_i = 1'b0;
    d_opcode_i = '0; d_size_i = '0; d_error_i = 1'b0; d_misc_i = '0;
    d_data_i = '0; d_rsp_intg_i = '0; d_data_intg_i = '0;
    test_reset();
    test_encode();
    test_back_to_back();
    test_check();
    test_saturate();
    test_passthrough();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
